// File: rtl/motor_reg_bank.sv
// motor_reg_bank
// Register bank and address decoder between the host byte bus and the
// swerve drive, swerve rotation and servo control outputs.
//
// Ports:
//   clock, reset         single clock, synchronous active-high reset
//   address, write_en,   host byte bus; one write per cycle, writes land on
//   wr_data, read_en     the edge where write_en is high
//   rd_data, rd_valid    registered read data, valid one cycle after read_en
//   fault, adc_temp,     per-channel fault and temperature inputs
//   current_angle        rotation channel angle inputs
//   brake, enable,       per-channel motor controls decoded from CONTROL
//   direction, pwm
//   target_angle         rotation channel target angles
//   servo_position       servo position registers
//   fault_any            registered OR of sticky fault bits
//   wdog_tripped         host-silence watchdog trip flag
//
// Address map: 0x00 ID, 0x01..0x03 CONTROL broadcasts (all / rotation /
// drive), 0x04 GLOBAL_STATUS, channel c at 0x08+4c (CONTROL, STATUS,
// TARG_ANG, CURR_ANG), servo s at 0x08+4*NCH+s.
//
// Build option: define MOTOR_REG_BANK_WDOG_EN to include the host-silence
// watchdog. Without it GLOBAL_STATUS bit0 reads 0 and wdog_tripped is 0.

module motor_reg_bank #(
    parameter int         NUM_DRIVE   = 4,
    parameter int         NUM_ROT     = 4,
    parameter int         NUM_SERVO   = 4,
    parameter int         ADDR_W      = 6,
    parameter logic [7:0] BLOCK_ID    = 8'hA5,
    parameter int         WDOG_CYCLES = 1000000
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [ADDR_W-1:0]                   address,
    input  logic                                write_en,
    input  logic [7:0]                          wr_data,
    input  logic                                read_en,
    output logic [7:0]                          rd_data,
    output logic                                rd_valid,
    input  logic [NUM_DRIVE+NUM_ROT-1:0]        fault,
    input  logic [7*(NUM_DRIVE+NUM_ROT)-1:0]    adc_temp,
    input  logic [8*NUM_ROT-1:0]                current_angle,
    output logic [NUM_DRIVE+NUM_ROT-1:0]        brake,
    output logic [NUM_DRIVE+NUM_ROT-1:0]        enable,
    output logic [NUM_DRIVE+NUM_ROT-1:0]        direction,
    output logic [5*(NUM_DRIVE+NUM_ROT)-1:0]    pwm,
    output logic [8*NUM_ROT-1:0]                target_angle,
    output logic [8*NUM_SERVO-1:0]              servo_position,
    output logic                                fault_any,
    output logic                                wdog_tripped
);

    localparam int NCH        = NUM_DRIVE + NUM_ROT;
    localparam int SERVO_BASE = 8 + 4 * NCH;

    localparam logic [ADDR_W-1:0] ADDR_ID     = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_BC_ALL = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_BC_ROT = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] ADDR_BC_DRV = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] ADDR_GSTAT  = ADDR_W'(4);

    // Elaboration-time sanity checks on the configuration.
    if (WDOG_CYCLES < 2) begin : g_bad_wdog
        $error("motor_reg_bank: WDOG_CYCLES must be at least 2");
    end
    if (SERVO_BASE + NUM_SERVO > (1 << ADDR_W)) begin : g_bad_addr_w
        $error("motor_reg_bank: ADDR_W too narrow for the register map");
    end

    // Flattened register views used by the read mux.
    logic [8*NCH-1:0]       ctrl_vec;
    logic [8*NCH-1:0]       status_vec;
    logic [NCH-1:0]         sticky_vec;
    logic [8*NUM_ROT-1:0]   targ_vec;
    logic [8*NUM_ROT-1:0]   curr_vec;
    logic [8*NUM_SERVO-1:0] servo_vec;

    // High while the watchdog counter sits at its terminal count.
    logic wdog_hit;

    // ------------------------------------------------------------------
    // Per-channel CONTROL, sticky fault and temperature sample
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        localparam logic [ADDR_W-1:0] ADDR_CTRL = ADDR_W'(8 + 4 * gi);
        localparam logic [ADDR_W-1:0] ADDR_STAT = ADDR_W'(9 + 4 * gi);
        localparam bit                IS_ROT    = (gi >= NUM_DRIVE);

        logic [7:0] ctrl_q, ctrl_d;
        logic       sticky_q, sticky_d;
        logic [6:0] temp_q, temp_d;
        logic       ctrl_hit;
        logic       sticky_clr;

        always_comb begin
            ctrl_hit = (address == ADDR_CTRL) || (address == ADDR_BC_ALL) ||
                       (IS_ROT ? (address == ADDR_BC_ROT) : (address == ADDR_BC_DRV));
            ctrl_d = ctrl_q;
            if (write_en && ctrl_hit) begin
                ctrl_d = wr_data;
            end
            // Watchdog enable clear overrides a host write in the same cycle;
            // the other CONTROL bits still take the written value.
            if (wdog_hit) begin
                ctrl_d[6] = 1'b0;
            end

            // A new fault in the same cycle as a clear keeps the bit set.
            sticky_clr = write_en && (address == ADDR_STAT) && wr_data[7];
            sticky_d   = fault[gi] | (sticky_q & ~sticky_clr);

            temp_d = adc_temp[7*gi +: 7];
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                ctrl_q   <= '0;
                sticky_q <= 1'b0;
                temp_q   <= '0;
            end else begin
                ctrl_q   <= ctrl_d;
                sticky_q <= sticky_d;
                temp_q   <= temp_d;
            end
        end

        assign brake[gi]             = ctrl_q[7];
        assign enable[gi]            = ctrl_q[6];
        assign direction[gi]         = ctrl_q[5];
        assign pwm[5*gi +: 5]        = ctrl_q[4:0];
        assign ctrl_vec[8*gi +: 8]   = ctrl_q;
        assign status_vec[8*gi +: 8] = {sticky_q, temp_q};
        assign sticky_vec[gi]        = sticky_q;
    end

    // ------------------------------------------------------------------
    // Rotation channels: target and current angle
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_ROT; gi++) begin : g_rot
        localparam logic [ADDR_W-1:0] ADDR_TARG = ADDR_W'(8 + 4 * (NUM_DRIVE + gi) + 2);

        logic [7:0] targ_q, targ_d;
        logic [7:0] curr_q, curr_d;

        always_comb begin
            targ_d = targ_q;
            if (write_en && (address == ADDR_TARG)) begin
                targ_d = wr_data;
            end
            curr_d = current_angle[8*gi +: 8];
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                targ_q <= '0;
                curr_q <= '0;
            end else begin
                targ_q <= targ_d;
                curr_q <= curr_d;
            end
        end

        assign target_angle[8*gi +: 8] = targ_q;
        assign targ_vec[8*gi +: 8]     = targ_q;
        assign curr_vec[8*gi +: 8]     = curr_q;
    end

    // ------------------------------------------------------------------
    // Servo position registers
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_SERVO; gi++) begin : g_servo
        localparam logic [ADDR_W-1:0] ADDR_SERVO = ADDR_W'(SERVO_BASE + gi);

        logic [7:0] servo_q, servo_d;

        always_comb begin
            servo_d = servo_q;
            if (write_en && (address == ADDR_SERVO)) begin
                servo_d = wr_data;
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                servo_q <= '0;
            end else begin
                servo_q <= servo_d;
            end
        end

        assign servo_position[8*gi +: 8] = servo_q;
        assign servo_vec[8*gi +: 8]      = servo_q;
    end

    // ------------------------------------------------------------------
    // Host-silence watchdog
    // ------------------------------------------------------------------
`ifdef MOTOR_REG_BANK_WDOG_EN
    localparam int               CNT_W   = $clog2(WDOG_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WDOG_CYCLES - 1);

    logic [CNT_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic             wdog_trip_q, wdog_trip_d;

    assign wdog_hit = (wdog_cnt_q == CNT_MAX);

    always_comb begin
        wdog_cnt_d = wdog_cnt_q;
        if (write_en) begin
            wdog_cnt_d = '0;
        end else if (!wdog_hit) begin
            wdog_cnt_d = wdog_cnt_q + CNT_W'(1);
        end

        // The W1C write also reloads the counter, so letting the clear win
        // here means the flag really drops even if the count was saturated.
        wdog_trip_d = wdog_trip_q | wdog_hit;
        if (write_en && (address == ADDR_GSTAT) && wr_data[0]) begin
            wdog_trip_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wdog_cnt_q  <= '0;
            wdog_trip_q <= 1'b0;
        end else begin
            wdog_cnt_q  <= wdog_cnt_d;
            wdog_trip_q <= wdog_trip_d;
        end
    end

    assign wdog_tripped = wdog_trip_q;
`else
    assign wdog_hit     = 1'b0;
    assign wdog_tripped = 1'b0;
`endif

    // ------------------------------------------------------------------
    // fault_any, read mux and registered read port
    // ------------------------------------------------------------------
    logic       fault_any_q, fault_any_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       rd_valid_q, rd_valid_d;
    logic [7:0] rd_mux;

    // Reads see register state from before this cycle's write.
    always_comb begin
        rd_mux = 8'h00;
        if (address == ADDR_ID) begin
            rd_mux = BLOCK_ID;
        end else if (address == ADDR_GSTAT) begin
            rd_mux = {6'b0, fault_any_q, wdog_tripped};
        end
        for (int c = 0; c < NCH; c++) begin
            if (address == ADDR_W'(8 + 4 * c)) rd_mux = ctrl_vec[8*c +: 8];
            if (address == ADDR_W'(9 + 4 * c)) rd_mux = status_vec[8*c +: 8];
        end
        for (int r = 0; r < NUM_ROT; r++) begin
            if (address == ADDR_W'(8 + 4 * (NUM_DRIVE + r) + 2)) rd_mux = targ_vec[8*r +: 8];
            if (address == ADDR_W'(8 + 4 * (NUM_DRIVE + r) + 3)) rd_mux = curr_vec[8*r +: 8];
        end
        for (int s = 0; s < NUM_SERVO; s++) begin
            if (address == ADDR_W'(SERVO_BASE + s)) rd_mux = servo_vec[8*s +: 8];
        end

        fault_any_d = |sticky_vec;
        rd_valid_d  = read_en;
        rd_data_d   = read_en ? rd_mux : rd_data_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fault_any_q <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            fault_any_q <= fault_any_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign fault_any = fault_any_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_motor_reg_bank.sv
module tb_motor_reg_bank;

    localparam int NUM_DRIVE = 4;
    localparam int NUM_ROT   = 4;
    localparam int NUM_SERVO = 4;
    localparam int ADDR_W    = 6;
    localparam int NCH       = NUM_DRIVE + NUM_ROT;

    logic                   clock = 1'b0;
    logic                   reset;
    logic [ADDR_W-1:0]      address;
    logic                   write_en;
    logic [7:0]             wr_data;
    logic                   read_en;
    logic [7:0]             rd_data;
    logic                   rd_valid;
    logic [NCH-1:0]         fault;
    logic [7*NCH-1:0]       adc_temp;
    logic [8*NUM_ROT-1:0]   current_angle;
    logic [NCH-1:0]         brake;
    logic [NCH-1:0]         enable;
    logic [NCH-1:0]         direction;
    logic [5*NCH-1:0]       pwm;
    logic [8*NUM_ROT-1:0]   target_angle;
    logic [8*NUM_SERVO-1:0] servo_position;
    logic                   fault_any;
    logic                   wdog_tripped;

    motor_reg_bank #(
        .NUM_DRIVE   (NUM_DRIVE),
        .NUM_ROT     (NUM_ROT),
        .NUM_SERVO   (NUM_SERVO),
        .ADDR_W      (ADDR_W),
        .BLOCK_ID    (8'hA5),
        .WDOG_CYCLES (16)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .address        (address),
        .write_en       (write_en),
        .wr_data        (wr_data),
        .read_en        (read_en),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .fault          (fault),
        .adc_temp       (adc_temp),
        .current_angle  (current_angle),
        .brake          (brake),
        .enable         (enable),
        .direction      (direction),
        .pwm            (pwm),
        .target_angle   (target_angle),
        .servo_position (servo_position),
        .fault_any      (fault_any),
        .wdog_tripped   (wdog_tripped)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Scoreboard of expected read data, pushed at issue, popped on rd_valid.
    logic [7:0] exp_q[$];
    string      tag_q[$];

    // Bench model of the CONTROL registers.
    logic [7:0] m_ctrl [NCH];

`ifdef MOTOR_REG_BANK_WDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [NCH-1:0] m_bit(input int b);
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_ctrl[c][b];
        return v;
    endfunction

    function automatic logic [5*NCH-1:0] m_pwm();
        logic [5*NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[5*c +: 5] = m_ctrl[c][4:0];
        return v;
    endfunction

    task automatic check_ctrl(input string tag);
        check({tag, "_brake"}, brake,     m_bit(7));
        check({tag, "_en"},    enable,    m_bit(6));
        check({tag, "_dir"},   direction, m_bit(5));
        check({tag, "_pwm"},   pwm,       m_pwm());
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        address  = a;
        wr_data  = d;
        write_en = 1'b1;
        @(posedge clock);
        #1;
        write_en = 1'b0;
        $display("write addr=%h data=%h", a, d);
    endtask

    // Waits (bounded) for rd_valid, then pops the scoreboard.
    task automatic collect();
        int         n;
        logic [7:0] e;
        string      t;
        n = 0;
        while (rd_valid !== 1'b1 && n < 4) begin
            @(posedge clock);
            #1;
            n++;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, "_valid"}, rd_valid, 1'b1);
        check(t, rd_data, e);
        $display("read  %s addr=%h data=%h expected=%h", t, address, rd_data, e);
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input logic [7:0] e, input string t);
        address = a;
        read_en = 1'b1;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(posedge clock);
        #1;
        read_en = 1'b0;
        collect();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset         = 1'b1;
        address       = '0;
        write_en      = 1'b0;
        wr_data       = '0;
        read_en       = 1'b0;
        fault         = '0;
        current_angle = '0;
        for (int c = 0; c < NCH; c++) begin
            adc_temp[7*c +: 7] = 7'(8'h10 + c);
            m_ctrl[c]          = 8'h00;
        end
        idle(3);
        reset = 1'b0;

        // Reset state
        check_ctrl("rst");
        check("rst_targ",  target_angle,   '0);
        check("rst_servo", servo_position, '0);
        check("rst_fany",  fault_any,      1'b0);
        check("rst_wdog",  wdog_tripped,   1'b0);
        check("rst_rdata", rd_data,        8'h00);
        check("rst_rvalid", rd_valid,      1'b0);

        // ID and unmapped reads; rd_valid is a single pulse, data holds
        rd(6'h00, 8'hA5, "id");
        idle(1);
        check("id_pulse", rd_valid, 1'b0);
        check("id_hold",  rd_data,  8'hA5);
        rd(6'h2C, 8'h00, "unmapped");

        // Rotation broadcast
        wr(6'h02, 8'hC3);
        for (int c = NUM_DRIVE; c < NCH; c++) m_ctrl[c] = 8'hC3;
        check_ctrl("bc_rot");
        rd(6'h18, 8'hC3, "ctrl4");
        rd(6'h08, 8'h00, "ctrl0");

        // All then drive broadcast
        wr(6'h01, 8'h8A);
        wr(6'h03, 8'h25);
        for (int c = 0; c < NCH; c++) m_ctrl[c] = (c < NUM_DRIVE) ? 8'h25 : 8'h8A;
        check_ctrl("bc_drv");
        rd(6'h0C, 8'h25, "ctrl1");
        rd(6'h1C, 8'h8A, "ctrl5");
        rd(6'h01, 8'h00, "bc_read");

        // Sticky fault, lagging fault_any, W1C, set-wins
        wr(6'h3F, 8'h00);
        fault = 8'h20;
        idle(1);
        fault = 8'h00;
        check("fany_lag", fault_any, 1'b0);
        idle(1);
        check("fany_set", fault_any, 1'b1);
        rd(6'h1D, 8'h95, "stat5_set");
        rd(6'h04, 8'h02, "gstat_fault");
        wr(6'h1D, 8'h80);
        rd(6'h1D, 8'h15, "stat5_clr");
        fault = 8'h20;
        wr(6'h1D, 8'h80);
        fault = 8'h00;
        rd(6'h1D, 8'h95, "stat5_setwins");
        wr(6'h1D, 8'h80);
        idle(1);
        check("fany_clr", fault_any, 1'b0);

        // Temperature lags its input by one cycle
        adc_temp[6:0] = 7'h33;
        rd(6'h09, 8'h10, "temp_old");
        rd(6'h09, 8'h33, "temp_new");

        // Target / current angle
        wr(6'h12, 8'h5A);
        rd(6'h12, 8'h00, "targ_drv");
        wr(6'h1A, 8'h5A);
        check("targ_out", target_angle, 32'h0000_005A);
        rd(6'h1A, 8'h5A, "targ4");
        current_angle = 32'h0000_7700;
        idle(1);
        rd(6'h1F, 8'h77, "curr5");
        rd(6'h13, 8'h00, "curr_drv");

        // Servos, plus read and write of the same address in one cycle
        wr(6'h28, 8'h11);
        wr(6'h2B, 8'h44);
        check("servo_out", servo_position, 32'h4400_0011);
        rd(6'h2B, 8'h44, "servo3");
        address  = 6'h29;
        wr_data  = 8'h66;
        write_en = 1'b1;
        read_en  = 1'b1;
        exp_q.push_back(8'h00);
        tag_q.push_back("rw_same");
        @(posedge clock);
        #1;
        write_en = 1'b0;
        read_en  = 1'b0;
        collect();
        check("servo_rw", servo_position, 32'h4400_6611);

        // Watchdog
        wr(6'h08, 8'h41);
        m_ctrl[0] = 8'h41;
        idle(8);
        check_ctrl("wd_early");
        idle(12);
        if (WDOG_ON) begin
            for (int c = 0; c < NCH; c++) m_ctrl[c][6] = 1'b0;
        end
        check_ctrl("wd_idle");
        check("wd_trip", wdog_tripped, WDOG_ON);
        rd(6'h04, WDOG_ON ? 8'h01 : 8'h00, "gstat_wdog");
        // Enable write issued while saturated is overridden by the clear
        wr(6'h08, 8'h41);
        check("wd_sat_en", enable[0], !WDOG_ON);
        wr(6'h04, 8'h01);
        check("wd_w1c", wdog_tripped, 1'b0);

        // Reset mid-burst, with a write on the reset edge
        rd(6'h00, 8'hA5, "pre_rst");
        wr(6'h2A, 8'h12);
        wr(6'h1E, 8'h34);
        address  = 6'h08;
        wr_data  = 8'hFF;
        write_en = 1'b1;
        reset    = 1'b1;
        @(posedge clock);
        #1;
        write_en = 1'b0;
        for (int c = 0; c < NCH; c++) m_ctrl[c] = 8'h00;
        check_ctrl("mid_rst");
        check("mid_rst_targ",  target_angle,   '0);
        check("mid_rst_servo", servo_position, '0);
        check("mid_rst_rdata", rd_data,        8'h00);
        check("mid_rst_fany",  fault_any,      1'b0);
        check("mid_rst_wdog",  wdog_tripped,   1'b0);
        reset = 1'b0;
        rd(6'h08, 8'h00, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
